// File: rtl/bc_trail_if.sv
// Breadcrumb handshake bundle between the trail and its external FIFO buffer.
// The trail connects through the slave modport; the buffer side uses master.
interface bc_trail_if #(
   parameter int unsigned WIDTH = 16
);
   logic             bc_in_valid;
   logic [WIDTH-1:0] bc_in_data;
   logic             bc_in_rdy;
   logic             bc_out_valid;
   logic             bc_out_rdy;
   logic [WIDTH-1:0] bc_out_data;

   modport master (
      output bc_in_valid,
      output bc_in_data,
      output bc_out_rdy,
      input  bc_in_rdy,
      input  bc_out_valid,
      input  bc_out_data
   );

   modport slave (
      input  bc_in_valid,
      input  bc_in_data,
      input  bc_out_rdy,
      output bc_in_rdy,
      output bc_out_valid,
      output bc_out_data
   );
endinterface

// File: rtl/bc_trail.sv
// Breadcrumb trail: captures breadcrumbs from a buffer into a LIFO and, on request,
// replays them newest-first back into the buffer.
module bc_trail #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   bc_trail_if.slave              bus,
   input  logic                   retrace_start,
   output logic                   retrace_busy,
   output logic                   retrace_done,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, CAPTURE, RETRACE, DONE} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count_next;
   logic             pending, pending_next;
   logic             in_rdy_c;
   logic             wr_en;
   logic             out_valid_next;
   logic             done_next;
   logic [WIDTH-1:0] out_data_next;
   logic [AW-1:0]    wr_idx;
   logic [AW-1:0]    rd_idx;
   logic [WIDTH-1:0] mem [DEPTH];

   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);
   assign wr_idx = AW'(count);
   assign rd_idx = AW'(count_next - CW'(1));

   // Read strobe must coincide with the IDLE decision so the popped word lands in CAPTURE.
   assign bus.bc_in_rdy = in_rdy_c;

   // Next-state, counter and next-output decode.
   always_comb begin
      state_next   = state;
      count_next   = count;
      pending_next = pending;
      in_rdy_c     = 1'b0;
      wr_en        = 1'b0;
      case (state)
         IDLE: begin
            if (retrace_start || pending) begin
               pending_next = 1'b0;
               state_next   = empty ? DONE : RETRACE;
            end else if (bus.bc_in_valid && !full) begin
               in_rdy_c   = 1'b1;
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            wr_en      = 1'b1;
            count_next = count + CW'(1);
            state_next = IDLE;
            if (retrace_start) pending_next = 1'b1;
         end
         RETRACE: begin
            if (bus.bc_out_rdy && !empty) begin
               count_next = count - CW'(1);
               if (count == CW'(1)) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (rst) in_rdy_c = 1'b0;
      out_valid_next = (state_next == RETRACE);
      done_next      = (state_next == DONE);
      out_data_next  = out_valid_next ? mem[rd_idx] : '0;
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         count            <= '0;
         pending          <= 1'b0;
         bus.bc_out_valid <= 1'b0;
         bus.bc_out_data  <= '0;
         retrace_busy     <= 1'b0;
         retrace_done     <= 1'b0;
      end else begin
         state            <= state_next;
         count            <= count_next;
         pending          <= pending_next;
         bus.bc_out_valid <= out_valid_next;
         bus.bc_out_data  <= out_data_next;
         retrace_busy     <= out_valid_next;
         retrace_done     <= done_next;
      end
   end

   // Trail storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem[wr_idx] <= bus.bc_in_data;
   end
endmodule

// File: doc/bc_trail.md
BC_TRAIL -- requirements
Module: bc_trail

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DEPTH, 64, trail capacity in entries.
- WIDTH, 16, breadcrumb width in bits.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock for all logic.
- rst, in, 1, synchronous active-high reset.
- bc_in_valid, in, 1, new breadcrumb available; driven by buffer ctrl_out_valid (FIFO not-empty).
- bc_in_data, in, WIDTH, new breadcrumb; driven by buffer ctrl_out_data; valid 1 cycle after bc_in_rdy pulse.
- bc_in_rdy, out, 1, single-cycle read strobe; drives buffer ctrl_out_rdy.
- bc_out_valid, out, 1, retrace breadcrumb valid; drives buffer ctrl_in_valid.
- bc_out_rdy, in, 1, buffer can accept; driven by buffer ctrl_in_rdy (FIFO not-full).
- bc_out_data, out, WIDTH, retrace breadcrumb; drives buffer ctrl_in_data.
- retrace_start, in, 1, single-cycle request to replay trail newest-first.
- retrace_busy, out, 1, high while retrace in progress.
- retrace_done, out, 1, single-cycle pulse at retrace end.
- count, out, clog2(DEPTH)+1, entries currently stored.
- full, out, 1, count == DEPTH.
- empty, out, 1, count == 0.
REQ-003 The block SHALL use one clock, clk; reset, rst, SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL store breadcrumbs in a LIFO of DEPTH x WIDTH entries, write pointer equal to count.
REQ-005 FSM states SHALL be IDLE, CAPTURE, RETRACE, DONE.
REQ-006 IDLE priority: (1) retrace_start or pending-retrace -> RETRACE if count>0, else DONE; (2) bc_in_valid && !full -> assert bc_in_rdy for exactly one cycle, go CAPTURE; (3) else stay.
REQ-007 CAPTURE SHALL write bc_in_data to mem[count], increment count, return to IDLE; capture throughput is one entry per 2 cycles.
REQ-008 bc_in_rdy SHALL never be asserted in CAPTURE, RETRACE, DONE, or when full; when full, new breadcrumbs SHALL stall in the buffer (no drop).
REQ-009 retrace_start arriving in CAPTURE SHALL set a pending flag, consumed on the next IDLE cycle; retrace_start in RETRACE or DONE SHALL be ignored.
REQ-010 RETRACE: bc_out_valid high, bc_out_data = mem[count-1], retrace_busy high; data SHALL be held stable while bc_out_valid && !bc_out_rdy.
REQ-011 On bc_out_valid && bc_out_rdy, count SHALL decrement; next cycle presents mem[count-2]; throughput one entry per cycle when bc_out_rdy stays high.
REQ-012 When the transfer of the last entry (count 1->0) completes, the FSM SHALL go to DONE; bc_out_valid SHALL deassert the cycle after the last transfer.
REQ-013 DONE SHALL pulse retrace_done for one cycle, then return to IDLE; retrace_busy low in DONE.
REQ-014 count SHALL never exceed DEPTH nor wrap below 0; full and empty SHALL be combinational from count.
REQ-015 bc_out_data SHALL be 0 whenever bc_out_valid is low.

Reset
REQ-016 On rst: state IDLE, count 0, pending flag 0, bc_in_rdy 0, bc_out_valid 0, bc_out_data 0, retrace_busy 0, retrace_done 0, full 0, empty 1.
REQ-017 rst mid-capture or mid-retrace SHALL abandon the operation with no further strobes; memory contents need not be cleared.

Verification
REQ-018 Capture: push 0x0001,0x0002,0x0003 via buffer model -> three bc_in_rdy pulses 2 cycles apart, count=3, empty=0.
REQ-019 Retrace: after REQ-018, pulse retrace_start, bc_out_rdy=1 -> bc_out_data 0x0003,0x0002,0x0001 on consecutive cycles, then retrace_done pulse, count=0.
REQ-020 Backpressure: during retrace drop bc_out_rdy for 4 cycles -> bc_out_valid high, bc_out_data frozen, count unchanged; resumes on rdy.
REQ-021 Full: DEPTH=64, offer 65 entries -> count=64, full=1, bc_in_rdy stays low, 65th entry remains in buffer (ctrl_out_valid=1).
REQ-022 Empty retrace and collision: retrace_start at count=0 -> retrace_done 1 cycle later, no bc_out_valid; retrace_start during CAPTURE -> retrace begins after that capture, newest entry first.
REQ-023 Reset mid-retrace: assert rst after 2 of 5 entries -> next cycle bc_out_valid=0, retrace_busy=0, count=0, no retrace_done.
